// File: rtl/tx_rst_seq.sv
// TX reset sequencer: releases per-stage resets lowest index first, gated on each stage's ready,
// then enables TX. All outputs registered; aborts to a sticky error on ready loss or timeout.
module tx_rst_seq #(
   parameter int N_STAGES = 3,
   parameter int HOLD_CYC = 16,
   parameter int TIMEOUT  = 1023
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            tru_rst,
   input  logic [N_STAGES-1:0]             stage_rdy,
   output logic [N_STAGES-1:0]             stage_rst,
   output logic                            tx_en,
   output logic                            seq_err,
   output logic [$clog2(N_STAGES+1)-1:0]   cur_stage
);

   localparam int SW = $clog2(N_STAGES+1);
   localparam int CW = $clog2(TIMEOUT+1);
   localparam logic [SW-1:0] LAST    = SW'(N_STAGES-1);
   localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD_CYC-1);
   localparam logic [CW-1:0] TMO     = CW'(TIMEOUT);

   typedef enum logic [1:0] {HOLD, WAIT, DONE, ERR} state_t;

   state_t                state, state_n;
   logic [CW-1:0]         cnt, cnt_n;
   logic [N_STAGES-1:0]   stage_rst_n;
   logic                  tx_en_n, seq_err_n;
   logic [SW-1:0]         cur_n;
   logic                  rdy_cur, lost, go_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= HOLD;
         cnt       <= '0;
         stage_rst <= '1;
         tx_en     <= 1'b0;
         seq_err   <= 1'b0;
         cur_stage <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         stage_rst <= stage_rst_n;
         tx_en     <= tx_en_n;
         seq_err   <= seq_err_n;
         cur_stage <= cur_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      stage_rst_n = stage_rst;
      tx_en_n     = tx_en;
      seq_err_n   = seq_err;
      cur_n       = cur_stage;
      rdy_cur     = 1'b0;
      lost        = 1'b0;
      go_err      = 1'b0;

      // ready of the stage being waited on, and loss of any already-released stage
      for (int j = 0; j < N_STAGES; j++) begin
         if (SW'(j) == cur_stage) rdy_cur = stage_rdy[j];
         if (SW'(j) < cur_stage && !stage_rdy[j]) lost = 1'b1;
      end

      if (tru_rst) begin
         state_n     = HOLD;
         cnt_n       = '0;
         stage_rst_n = '1;
         tx_en_n     = 1'b0;
         seq_err_n   = 1'b0;
         cur_n       = '0;
      end else begin
         case (state)
            HOLD: begin
               state_n        = WAIT;
               stage_rst_n    = '1;
               stage_rst_n[0] = 1'b0;
               tx_en_n        = 1'b0;
               cur_n          = '0;
               cnt_n          = '0;
            end
            WAIT: begin
               if (lost) begin
                  go_err = 1'b1;
               end else if (rdy_cur && cnt >= HOLD_M1) begin
                  cur_n = cur_stage + SW'(1);
                  cnt_n = '0;
                  if (cur_stage == LAST) begin
                     state_n = DONE;
                     tx_en_n = 1'b1;
                  end else begin
                     for (int j = 0; j < N_STAGES; j++)
                        if (SW'(j) == cur_stage + SW'(1)) stage_rst_n[j] = 1'b0;
                  end
               end else if (cnt == TMO) begin
                  go_err = 1'b1;
               end else begin
                  cnt_n = cnt + CW'(1);
               end
            end
            DONE: begin
               if (stage_rdy != '1) go_err = 1'b1;
            end
            default: ;
         endcase

         // cur_stage deliberately left frozen as the failing index
         if (go_err) begin
            state_n     = ERR;
            stage_rst_n = '1;
            tx_en_n     = 1'b0;
            seq_err_n   = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tx_rst_seq.sv
// Directed bench for tx_rst_seq (N=3, HOLD_CYC=16, TIMEOUT=1023) with hand-computed expectations.
module tb_tx_rst_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       tru_rst;
   logic [2:0] stage_rdy;
   logic [2:0] stage_rst;
   logic       tx_en;
   logic       seq_err;
   logic [1:0] cur_stage;

   int n_tests = 0;
   int n_fail  = 0;

   tx_rst_seq #(.N_STAGES(3), .HOLD_CYC(16), .TIMEOUT(1023)) dut (
      .clk       (clk),
      .rst       (rst),
      .tru_rst   (tru_rst),
      .stage_rdy (stage_rdy),
      .stage_rst (stage_rst),
      .tx_en     (tx_en),
      .seq_err   (seq_err),
      .cur_stage (cur_stage)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] e_rst, input logic e_en,
                          input logic e_err, input logic [1:0] e_cur);
      chk({tag, ".stage_rst"}, 32'(stage_rst), 32'(e_rst));
      chk({tag, ".tx_en"},     32'(tx_en),     32'(e_en));
      chk({tag, ".seq_err"},   32'(seq_err),   32'(e_err));
      chk({tag, ".cur_stage"}, 32'(cur_stage), 32'(e_cur));
   endtask

   initial begin
      rst = 1'b1; tru_rst = 1'b1; stage_rdy = 3'b000;
      step(2);
      chk_all("reset", 3'b111, 1'b0, 1'b0, 2'd0);
      rst = 1'b0;
      step(1);
      chk_all("hold", 3'b111, 1'b0, 1'b0, 2'd0);

      // nominal sequence: releases at edges 1, 17, 33; tx_en at 49
      stage_rdy = 3'b111; tru_rst = 1'b0;
      step(1);  chk_all("nom.e1", 3'b110, 1'b0, 1'b0, 2'd0);
      step(15); chk("nom.e16.stage_rst", 32'(stage_rst), 32'h6);
      step(1);  chk_all("nom.e17", 3'b100, 1'b0, 1'b0, 2'd1);
      step(16); chk_all("nom.e33", 3'b000, 1'b0, 1'b0, 2'd2);
      step(15); chk("nom.e48.tx_en", 32'(tx_en), 32'h0);
      step(1);  chk_all("nom.e49", 3'b000, 1'b1, 1'b0, 2'd3);

      // ready loss in DONE
      stage_rdy = 3'b101;
      step(1);  chk_all("done_loss", 3'b111, 1'b0, 1'b1, 2'd3);
      stage_rdy = 3'b111;
      step(5);  chk_all("done_loss.sticky", 3'b111, 1'b0, 1'b1, 2'd3);
      tru_rst = 1'b1;
      step(1);  chk_all("err_clear", 3'b111, 1'b0, 1'b0, 2'd0);

      // slow ready on stage 1
      stage_rdy = 3'b001; tru_rst = 1'b0;
      step(1);
      step(16); chk_all("slow.rel1", 3'b100, 1'b0, 1'b0, 2'd1);
      step(99); chk_all("slow.waiting", 3'b100, 1'b0, 1'b0, 2'd1);
      stage_rdy = 3'b011;
      step(1);  chk_all("slow.rel2", 3'b000, 1'b0, 1'b0, 2'd2);
      stage_rdy = 3'b111;
      step(15); chk("slow.pre_en", 32'(tx_en), 32'h0);
      step(1);  chk_all("slow.done", 3'b000, 1'b1, 1'b0, 2'd3);

      // rst while in DONE
      rst = 1'b1;
      step(1);  chk_all("rst_done", 3'b111, 1'b0, 1'b0, 2'd0);
      rst = 1'b0;

      // tru_rst while waiting on stage 1
      step(17); chk_all("tru.wait1", 3'b100, 1'b0, 1'b0, 2'd1);
      tru_rst = 1'b1;
      step(1);  chk_all("tru.hold", 3'b111, 1'b0, 1'b0, 2'd0);

      // timeout on stage 0: cnt hits 1023 after edge 1024, ERR at edge 1025
      stage_rdy = 3'b000; tru_rst = 1'b0;
      step(1);
      step(1023); chk_all("tmo.pre", 3'b110, 1'b0, 1'b0, 2'd0);
      step(1);    chk_all("tmo.err", 3'b111, 1'b0, 1'b1, 2'd0);
      tru_rst = 1'b1;
      step(1);  chk("tmo.clear.seq_err", 32'(seq_err), 32'h0);
      tru_rst = 1'b0; stage_rdy = 3'b111;
      step(1);  chk_all("tmo.restart", 3'b110, 1'b0, 1'b0, 2'd0);

      // boundary: ready rises exactly at cnt==TIMEOUT, advance wins
      tru_rst = 1'b1;
      step(1);
      stage_rdy = 3'b000; tru_rst = 1'b0;
      step(1);
      step(1023);
      stage_rdy = 3'b001;
      step(1);  chk_all("bnd.adv", 3'b100, 1'b0, 1'b0, 2'd1);

      // ready loss of stage 0 while waiting on stage 1
      stage_rdy = 3'b000;
      step(1);  chk_all("wait_loss", 3'b111, 1'b0, 1'b1, 2'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
